// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle controller: opcodes, datapath mux/ALU selects,
// FSM states and decoded instruction classes.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_LUI   = 3'd4;
  localparam logic [2:0] ALU_FUNCT = 3'd7;

  localparam logic [1:0] SRCB_REG     = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] PC_ALU     = 2'd0;
  localparam logic [1:0] PC_ALU_OUT = 2'd1;
  localparam logic [1:0] PC_JUMP    = 2'd2;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
    WB_ALU, WB_MEM, BRANCH, JUMP
  } state_t;

  typedef enum logic [2:0] {
    CL_R, CL_I, CL_LW, CL_SW, CL_BEQ, CL_J, CL_JAL, CL_ILL
  } instr_class_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_we;
  logic       ir_we;
  logic       mem_req;
  logic       mem_we;
  logic       reg_we;
  logic       ext_op;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] reg_dst;
  logic [1:0] pc_src;
  logic       illegal;
  logic       bus_err;
  logic       instr_done;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_we, ir_we, mem_req, mem_we, reg_we, ext_op, mem_to_reg, alu_src_a,
           alu_src_b, alu_op, reg_dst, pc_src, illegal, bus_err, instr_done
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_we, ir_we, mem_req, mem_we, reg_we, ext_op, mem_to_reg, alu_src_a,
           alu_src_b, alu_op, reg_dst, pc_src, illegal, bus_err, instr_done
  );
endinterface

// File: rtl/ctrl_dec.sv
// Combinational opcode decode: instruction class, immediate extension, ALU op, legality.
// MULTICYCLE_CTRL_JAL_EN makes jal (000011) a legal jump-and-link.
module ctrl_dec
  import cpu_pkg::*;
(
  input  logic [5:0]   opcode,
  output instr_class_t cls,
  output logic         ext_op,
  output logic [2:0]   alu_op,
  output logic         legal
);

  always_comb begin
    cls    = CL_ILL;
    ext_op = 1'b1;
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (opcode)
      OP_RTYPE: begin cls = CL_R; alu_op = ALU_FUNCT; end
      OP_ADDIU: cls = CL_I;
      OP_ANDI:  begin cls = CL_I; ext_op = 1'b0; alu_op = ALU_AND; end
      OP_ORI:   begin cls = CL_I; ext_op = 1'b0; alu_op = ALU_OR;  end
      OP_LUI:   begin cls = CL_I; ext_op = 1'b0; alu_op = ALU_LUI; end
      OP_LW:    cls = CL_LW;
      OP_SW:    cls = CL_SW;
      OP_BEQ:   begin cls = CL_BEQ; alu_op = ALU_SUB; end
      OP_J:     cls = CL_J;
`ifdef MULTICYCLE_CTRL_JAL_EN
      OP_JAL:   cls = CL_JAL;
`endif
      default:  begin cls = CL_ILL; legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM with memory wait timeout (MEM_TIMEOUT).
// MULTICYCLE_CTRL_JAL_EN adds jal handling in JUMP.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  state_t       state;
  logic [7:0]   wait_cnt;
  instr_class_t cls;
  logic         dec_ext_op;
  logic [2:0]   dec_alu_op;
  logic         dec_legal;
  logic         in_wait;
  logic         timed_out;

  ctrl_dec u_dec (
    .opcode (bus.opcode),
    .cls    (cls),
    .ext_op (dec_ext_op),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  assign in_wait   = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign timed_out = in_wait && !bus.mem_ready && (wait_cnt == 8'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      // Counter only advances while stalled; every exit (incl. FETCH->FETCH timeout) clears it.
      if (in_wait && !bus.mem_ready && !timed_out) wait_cnt <= wait_cnt + 8'd1;
      else                                         wait_cnt <= '0;

      case (state)
        FETCH:    if (bus.mem_ready) state <= DECODE;
        DECODE: begin
          case (cls)
            CL_R:         state <= EXEC_R;
            CL_I:         state <= EXEC_I;
            CL_LW, CL_SW: state <= MEM_ADDR;
            CL_BEQ:       state <= BRANCH;
            CL_J, CL_JAL: state <= JUMP;
            default:      state <= FETCH;
          endcase
        end
        EXEC_R, EXEC_I: state <= WB_ALU;
        MEM_ADDR: state <= (cls == CL_LW) ? MEM_RD : MEM_WR;
        MEM_RD: begin
          if (bus.mem_ready)  state <= WB_MEM;
          else if (timed_out) state <= FETCH;
        end
        MEM_WR:   if (bus.mem_ready || timed_out) state <= FETCH;
        default:  state <= FETCH;
      endcase
    end
  end

  // Outputs decode from state (plus mem_ready/zero) so handshakes complete in the same cycle.
  always_comb begin
    bus.pc_we      = 1'b0;
    bus.ir_we      = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.reg_we     = 1'b0;
    bus.ext_op     = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_REG;
    bus.alu_op     = ALU_ADD;
    bus.reg_dst    = DST_RT;
    bus.pc_src     = PC_ALU;
    bus.illegal    = 1'b0;
    bus.bus_err    = 1'b0;
    bus.instr_done = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          bus.alu_src_b = SRCB_FOUR;
          bus.mem_req   = ~timed_out;
          bus.bus_err   = timed_out;
          bus.ir_we     = bus.mem_ready;
          bus.pc_we     = bus.mem_ready;
        end
        DECODE: begin
          bus.ext_op    = 1'b1;
          bus.alu_src_b = SRCB_IMM_SL2;
          bus.illegal   = ~dec_legal;
        end
        EXEC_R: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = ALU_FUNCT;
        end
        EXEC_I, MEM_ADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
          bus.ext_op    = dec_ext_op;
          bus.alu_op    = dec_alu_op;
        end
        MEM_RD: begin
          bus.mem_req = ~timed_out;
          bus.bus_err = timed_out;
        end
        MEM_WR: begin
          bus.mem_req    = ~timed_out;
          bus.mem_we     = ~timed_out;
          bus.bus_err    = timed_out;
          bus.instr_done = bus.mem_ready;
        end
        WB_ALU: begin
          bus.reg_we     = 1'b1;
          bus.reg_dst    = (cls == CL_R) ? DST_RD : DST_RT;
          bus.instr_done = 1'b1;
        end
        WB_MEM: begin
          bus.reg_we     = 1'b1;
          bus.mem_to_reg = 1'b1;
          bus.instr_done = 1'b1;
        end
        BRANCH: begin
          bus.alu_src_a  = 1'b1;
          bus.alu_op     = ALU_SUB;
          bus.pc_src     = PC_ALU_OUT;
          bus.pc_we      = bus.zero;
          bus.instr_done = 1'b1;
        end
        JUMP: begin
          bus.pc_we      = 1'b1;
          bus.pc_src     = PC_JUMP;
          bus.instr_done = 1'b1;
          if (cls == CL_JAL) begin
            bus.reg_we  = 1'b1;
            bus.reg_dst = DST_RA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected cycle traces built
// from the instruction timing rules, driven with randomized wait/ready/zero stimulus.
module tb_multicycle_ctrl;

  localparam int unsigned T = 15;

  localparam logic [7:0] PCWE = 8'h80, IRWE = 8'h40, REQ = 8'h20, MWE = 8'h10;
  localparam logic [7:0] RWE  = 8'h08, ILL  = 8'h04, BERR = 8'h02, DONE = 8'h01;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        ready;
    logic [5:0]  op;
    logic        z;
    logic [18:0] val;
    logic [18:0] msk;
    logic [63:0] tag;
  } cyc_t;

  cyc_t plan[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [5:0] pool [12] = '{6'b000000, 6'b001001, 6'b001100, 6'b001101, 6'b001111, 6'b100011,
                            6'b101011, 6'b000100, 6'b000010, 6'b000011, 6'b111111, 6'b010000};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {pc_we ir_we mem_req mem_we reg_we illegal bus_err instr_done ext_op mem_to_reg src_b alu_op reg_dst pc_src}
  function automatic logic [18:0] observed();
    return {bus.pc_we, bus.ir_we, bus.mem_req, bus.mem_we, bus.reg_we, bus.illegal, bus.bus_err,
            bus.instr_done, bus.ext_op, bus.mem_to_reg, bus.alu_src_b, bus.alu_op, bus.reg_dst,
            bus.pc_src};
  endfunction

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b001001, 6'b001100, 6'b001101, 6'b001111,
      6'b100011, 6'b101011, 6'b000100, 6'b000010: return 1'b1;
`ifdef MULTICYCLE_CTRL_JAL_EN
      6'b000011: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Field arguments of -1 mean "not constrained in this cycle".
  task automatic push(input logic [63:0] tag, input logic rdy, input logic [5:0] op, input logic z,
                      input logic [7:0] strb, input int ext, input int m2r, input int srcb,
                      input int aop, input int rdst, input int psrc);
    cyc_t c;
    c.tag = tag; c.ready = rdy; c.op = op; c.z = z;
    c.val = {strb, 11'b0};
    c.msk = {8'hff, 11'b0};
    if (ext  >= 0) begin c.val[10]  = 1'(ext);  c.msk[10]  = 1'b1; end
    if (m2r  >= 0) begin c.val[9]   = 1'(m2r);  c.msk[9]   = 1'b1; end
    if (srcb >= 0) begin c.val[8:7] = 2'(srcb); c.msk[8:7] = '1;   end
    if (aop  >= 0) begin c.val[6:4] = 3'(aop);  c.msk[6:4] = '1;   end
    if (rdst >= 0) begin c.val[3:2] = 2'(rdst); c.msk[3:2] = '1;   end
    if (psrc >= 0) begin c.val[1:0] = 2'(psrc); c.msk[1:0] = '1;   end
    plan.push_back(c);
  endtask

  // wf/wm: cycles mem_ready stays low in fetch / data access; > T means it never comes.
  task automatic plan_instr(input logic [5:0] op, input logic z, input int wf, input int wm);
    logic [5:0] junk;
    int         n;
    junk = 6'($urandom);
    n = (wf > int'(T)) ? int'(T) : wf;
    for (int i = 0; i < n; i++) push("fetch_w", 1'b0, junk, z, REQ, -1, -1, -1, -1, -1, -1);
    if (wf > int'(T)) begin
      push("fetch_to", 1'b0, junk, z, BERR, -1, -1, -1, -1, -1, -1);
      return;
    end
    push("fetch", 1'b1, junk, z, PCWE | IRWE | REQ, -1, -1, 1, 0, -1, 0);
    push("decode", rnd(), op, z, is_legal(op) ? 8'h00 : ILL, 1, -1, 3, 0, -1, -1);
    if (!is_legal(op)) return;
    n = (wm > int'(T)) ? int'(T) : wm;
    case (op)
      6'b000000: begin
        push("exec_r", rnd(), op, z, 8'h00, -1, -1, -1, 7, -1, -1);
        push("wb_r", rnd(), op, z, RWE | DONE, -1, 0, -1, -1, 1, -1);
      end
      6'b001001, 6'b001100, 6'b001101, 6'b001111: begin
        case (op)
          6'b001001: push("exec_i", rnd(), op, z, 8'h00, 1, -1, 2, 0, -1, -1);
          6'b001100: push("exec_i", rnd(), op, z, 8'h00, 0, -1, 2, 2, -1, -1);
          6'b001101: push("exec_i", rnd(), op, z, 8'h00, 0, -1, 2, 3, -1, -1);
          default:   push("exec_i", rnd(), op, z, 8'h00, 0, -1, 2, 4, -1, -1);
        endcase
        push("wb_i", rnd(), op, z, RWE | DONE, -1, 0, -1, -1, 0, -1);
      end
      6'b100011: begin
        push("mem_addr", rnd(), op, z, 8'h00, 1, -1, 2, 0, -1, -1);
        for (int i = 0; i < n; i++) push("rd_w", 1'b0, op, z, REQ, -1, -1, -1, -1, -1, -1);
        if (wm > int'(T)) push("rd_to", 1'b0, op, z, BERR, -1, -1, -1, -1, -1, -1);
        else begin
          push("rd", 1'b1, op, z, REQ, -1, -1, -1, -1, -1, -1);
          push("wb_mem", rnd(), op, z, RWE | DONE, -1, 1, -1, -1, 0, -1);
        end
      end
      6'b101011: begin
        push("mem_addr", rnd(), op, z, 8'h00, 1, -1, 2, 0, -1, -1);
        for (int i = 0; i < n; i++) push("wr_w", 1'b0, op, z, REQ | MWE, -1, -1, -1, -1, -1, -1);
        if (wm > int'(T)) push("wr_to", 1'b0, op, z, BERR, -1, -1, -1, -1, -1, -1);
        else              push("wr", 1'b1, op, z, REQ | MWE | DONE, -1, -1, -1, -1, -1, -1);
      end
      6'b000100: push("branch", rnd(), op, z, z ? (PCWE | DONE) : DONE, -1, -1, 0, 1, -1, 1);
      6'b000010: push("jump", rnd(), op, z, PCWE | DONE, -1, -1, -1, -1, -1, 2);
      default:   push("jal", rnd(), op, z, PCWE | RWE | DONE, -1, 0, -1, -1, 2, 2);
    endcase
  endtask

  // Entered at posedge+1: drive, check at negedge, return at next posedge+1.
  task automatic run_one();
    cyc_t c;
    c = plan.pop_front();
    bus.mem_ready = c.ready;
    bus.opcode    = c.op;
    bus.zero      = c.z;
    bus.funct     = 6'($urandom);
    @(negedge clk);
    check_eq($sformatf("%s", c.tag), 32'(observed() & c.msk), 32'(c.val & c.msk));
    @(posedge clk); #1;
  endtask

  task automatic run_plan();
    while (plan.size() > 0) run_one();
  endtask

  task automatic check_reset_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      bus.mem_ready = rnd();
      bus.opcode    = 6'($urandom);
      bus.zero      = rnd();
      @(negedge clk);
      check_eq(tag, 32'({bus.alu_src_a, observed()}), 32'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int wf, wm;
    logic [5:0] op;
    rst = 1'b1;
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    check_reset_cycles("reset", 3);
    rst = 1'b0;

    plan_instr(6'b001001, 1'b0, 0, 0);       // addiu
    plan_instr(6'b001101, 1'b1, 0, 0);       // ori
    plan_instr(6'b001111, 1'b0, 1, 0);       // lui
    plan_instr(6'b001100, 1'b0, 0, 0);       // andi
    plan_instr(6'b000000, 1'b1, 2, 0);       // R-type
    plan_instr(6'b100011, 1'b0, 0, 3);       // lw, 3 stall cycles
    plan_instr(6'b101011, 1'b0, 0, 2);       // sw
    plan_instr(6'b000100, 1'b1, 0, 0);       // beq taken
    plan_instr(6'b000100, 1'b0, 0, 0);       // beq not taken
    plan_instr(6'b000010, 1'b0, 0, 0);       // j
    plan_instr(6'b000011, 1'b0, 0, 0);       // jal
    plan_instr(6'b111111, 1'b0, 0, 0);       // illegal
    plan_instr(6'b000000, 1'b0, T + 1, 0);   // fetch timeout
    plan_instr(6'b001001, 1'b0, T, 0);       // ready on the timeout cycle
    plan_instr(6'b100011, 1'b1, 0, T);       // lw ready on the timeout cycle
    plan_instr(6'b100011, 1'b1, 0, T + 4);   // lw timeout
    plan_instr(6'b101011, 1'b0, 0, T + 4);   // sw timeout
    run_plan();

    // Reset landing in MEM_WR: fetch, decode, mem_addr, two write stalls, then rst.
    plan_instr(6'b101011, 1'b0, 0, T + 5);
    repeat (5) run_one();
    plan.delete();
    rst = 1'b1;
    check_reset_cycles("rst_mid", 2);
    rst = 1'b0;
    plan_instr(6'b000010, 1'b0, 2, 0);
    run_plan();

    for (int k = 0; k < 300; k++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : pool[$urandom_range(0, 11)];
      wf = ($urandom_range(0, 15) == 0) ? int'(T) + $urandom_range(0, 1) : $urandom_range(0, 3);
      wm = ($urandom_range(0, 7) == 0) ? int'(T) + $urandom_range(0, 1) : $urandom_range(0, 3);
      plan_instr(op, rnd(), wf, wm);
      run_plan();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
